// File: rtl/conv_window_gen_pkg.sv
// Shared constants, FSM state type and window indexing for the 3x3 window generator.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int KSIZE  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Flat element index of window row r (0 = oldest) and column c (0 = leftmost).
  function automatic int win_idx(input int r, input int c);
    return r * KSIZE + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Control, pixel-stream and window-stream signals between the window generator and its neighbours.
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int DIM_W  = 10
) ();

  logic                             start;
  logic [DIM_W-1:0]                 img_width;
  logic [DIM_W-1:0]                 img_height;
  logic [DATA_W-1:0]                pix_in;
  logic                             pix_valid;
  logic                             pix_ready;
  logic [KSIZE*KSIZE*DATA_W-1:0]    win_out;
  logic                             win_valid;
  logic                             win_ready;
  logic                             busy;
  logic                             frame_done;
  logic                             err;

  modport slave (
    input  start, img_width, img_height, pix_in, pix_valid, win_ready,
    output pix_ready, win_out, win_valid, busy, frame_done, err
  );

  modport master (
    output start, img_width, img_height, pix_in, pix_valid, win_ready,
    input  pix_ready, win_out, win_valid, busy, frame_done, err
  );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// Simple dual-port line RAM with a registered (one-cycle) read; a read and write to the
// same address in one cycle returns the old contents.
module conv_line_buffer #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one complete neighbourhood per word out.
// Two line buffers hold the previous rows; a small shift array supplies the older columns.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W    = conv_pkg::DATA_W,
  parameter int MAX_WIDTH = 640,
  parameter int DIM_W     = 10
) (
  input  logic             clock,
  input  logic             reset,
  conv_window_gen_if.slave io
);

  localparam int WIN_W = KSIZE * KSIZE * DATA_W;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic              err_q, err_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  win_next;

  logic [DATA_W-1:0] hist_q [KSIZE][KSIZE-1];
  logic [DATA_W-1:0] new_col [KSIZE];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  logic pix_ready, pix_acc, win_acc, win_load, geom_ok, last_col, last_pix;

  assign geom_ok  = (io.img_width  >= DIM_W'(KSIZE)) &&
                    (io.img_width  <= DIM_W'(MAX_WIDTH)) &&
                    (io.img_height >= DIM_W'(KSIZE));
  assign pix_ready = (state_q == RUN) && (!win_valid_q || io.win_ready);
  assign pix_acc   = pix_ready && io.pix_valid;
  assign win_acc   = win_valid_q && io.win_ready;
  assign last_col  = (col_q == width_q - DIM_W'(1));
  assign last_pix  = last_col && (row_q == height_q - DIM_W'(1));
  assign win_load  = pix_acc && (col_q >= DIM_W'(KSIZE-1)) && (row_q >= DIM_W'(KSIZE-1));

  // Stage 0: line-buffer read, addressed from col_d so data lines up with the next accept
  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_WIDTH), .ADDR_W(DIM_W)) u_lb0 (
    .clock     (clock),
    .we_i      (pix_acc),
    .wr_addr_i (col_q),
    .wr_data_i (io.pix_in),
    .rd_addr_i (col_d),
    .rd_data_o (lb0_rd)
  );

  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_WIDTH), .ADDR_W(DIM_W)) u_lb1 (
    .clock     (clock),
    .we_i      (pix_acc),
    .wr_addr_i (col_q),
    .wr_data_i (lb0_rd),
    .rd_addr_i (col_d),
    .rd_data_o (lb1_rd)
  );

  always_comb begin
    new_col[0] = lb1_rd;
    new_col[1] = lb0_rd;
    new_col[2] = io.pix_in;
  end

  always_comb begin
    win_next = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        win_next[DATA_W*win_idx(r, c) +: DATA_W] = hist_q[r][c];
      end
      win_next[DATA_W*win_idx(r, KSIZE-1) +: DATA_W] = new_col[r];
    end
  end

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    col_d        = col_q;
    row_d        = row_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    win_valid_d  = win_valid_q;
    win_d        = win_q;

    if (win_acc) begin
      win_valid_d = 1'b0;
    end
    if (win_load) begin
      win_valid_d = 1'b1;
      win_d       = win_next;
    end

    case (state_q)
      IDLE: begin
        if (io.start) begin
          if (geom_ok) begin
            width_d  = io.img_width;
            height_d = io.img_height;
            col_d    = '0;
            row_d    = '0;
            err_d    = 1'b0;
            state_d  = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (pix_acc) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
          if (last_pix) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Hold DRAIN through the frame_done cycle so a coincident start is ignored.
        if (frame_done_q) begin
          state_d = IDLE;
        end else if (win_acc) begin
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: control state and output window register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      err_q        <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      col_q        <= col_d;
      row_q        <= row_d;
      err_q        <= err_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  always_ff @(posedge clock) begin
    if (pix_acc) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 2; c++) begin
          hist_q[r][c] <= hist_q[r][c+1];
        end
        hist_q[r][KSIZE-2] <= new_col[r];
      end
    end
  end

  assign io.pix_ready  = pix_ready;
  assign io.win_out    = win_q;
  assign io.win_valid  = win_valid_q;
  assign io.busy       = (state_q != IDLE);
  assign io.frame_done = frame_done_q;
  assign io.err        = err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: windows are predicted from the stored image itself.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int DW   = 8;
  localparam int DIMW = 10;
  localparam int MAXW = 640;
  localparam int WW   = 9 * DW;

  typedef struct {
    int   w;
    int   h;
    logic exp_err;
    logic exp_busy;
  } geom_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.DATA_W(DW), .DIM_W(DIMW)) bus ();

  conv_window_gen #(.DATA_W(DW), .MAX_WIDTH(MAXW), .DIM_W(DIMW)) dut (
    .clock (clk),
    .reset (rst),
    .io    (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] img [$];
  logic [WW-1:0] got_q [$];
  int fd_count;
  int first_win_cyc;
  int br_acc_cyc;

  task automatic check_word(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Window whose top-left pixel is image (r, c): element 3*dr+dc = pixel (r+dr, c+dc).
  function automatic logic [WW-1:0] exp_win(input int w, input int r, input int c);
    logic [WW-1:0] v;
    v = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        v[DW*(3*dr+dc) +: DW] = img[(r+dr)*w + (c+dc)];
      end
    end
    return v;
  endfunction

  function automatic logic [WW-1:0] pack9(input int a[9]);
    logic [WW-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[DW*k +: DW] = DW'(a[k]);
    return v;
  endfunction

  task automatic fill_seq(input int n, input int base);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(DW'(base + i));
  endtask

  task automatic fill_rand(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(DW'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_pix_ready"},  bus.pix_ready,  1'b0);
    check_bit({tag, "_win_valid"},  bus.win_valid,  1'b0);
    check_word({tag, "_win_out"},   bus.win_out,    '0);
    check_bit({tag, "_busy"},       bus.busy,       1'b0);
    check_bit({tag, "_frame_done"}, bus.frame_done, 1'b0);
    check_bit({tag, "_err"},        bus.err,        1'b0);
  endtask

  // Drives one frame cycle by cycle from the negedge, recording every accepted window.
  task automatic stream(input int w, input int h, input bit do_start, input int gap_pct,
                        input int rdy_pct, input int stall_len, input bit start_at_done);
    int  sent = 0, cyc = 0, stall_left = 0, nexp, limit;
    bit  stalled = 0, done_seen = 0, poke = 0, finished = 0;
    logic [WW-1:0] held = '0;
    got_q.delete();
    fd_count = 0; first_win_cyc = -1; br_acc_cyc = -1;
    nexp  = (w - 2) * (h - 2);
    limit = 10 * w * h + 200;
    while (!finished && cyc < limit) begin
      @(negedge clk);
      bus.start = (do_start && cyc == 0) || poke;
      if (bus.start) begin
        bus.img_width  = DIMW'(w);
        bus.img_height = DIMW'(h);
      end
      bus.pix_valid = (sent < w*h) && (int'($urandom_range(99)) >= gap_pct);
      bus.pix_in    = (sent < w*h) ? img[sent] : DW'($urandom);
      bus.win_ready = (stall_left == 0) && (int'($urandom_range(99)) < rdy_pct);
      #1;
      if (poke) check_bit("frame_done_with_start", bus.frame_done, 1'b1);
      poke = 0;
      if (stall_left > 0) begin
        if (stall_left == stall_len) held = bus.win_out;
        else check_word("stall_win_hold", bus.win_out, held);
        if (bus.win_valid) check_bit("stall_pix_ready", bus.pix_ready, 1'b0);
        stall_left--;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (sent == 2*w + 2) br_acc_cyc = cyc;
        sent++;
      end
      if (bus.win_valid && first_win_cyc < 0) first_win_cyc = cyc;
      if (bus.win_valid && bus.win_ready) begin
        got_q.push_back(bus.win_out);
        if (stall_len > 0 && !stalled) begin
          stalled    = 1;
          stall_left = stall_len;
        end
        if (got_q.size() == nexp && start_at_done) poke = 1;
      end
      if (bus.frame_done) begin
        fd_count++;
        done_seen = 1;
      end else if (done_seen && !bus.busy) begin
        finished = 1;
      end
      cyc++;
    end
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b1;
    check_bit("frame_completes", finished, 1'b1);
  endtask

  task automatic compare_frame(input string tag, input int w, input int h);
    int nexp, n;
    nexp = (w - 2) * (h - 2);
    check_int({tag, "_win_count"}, got_q.size(), nexp);
    n = (got_q.size() < nexp) ? got_q.size() : nexp;
    for (int i = 0; i < n; i++) begin
      check_word({tag, "_win"}, got_q[i], exp_win(w, i / (w - 2), i % (w - 2)));
    end
    check_int({tag, "_frame_done_pulses"}, fd_count, 1);
    check_int({tag, "_latency"}, first_win_cyc - br_acc_cyc, 1);
  endtask

  initial begin
    geom_vec_t gv [5];
    int fw[9], lw[9];
    int n, cyc;

    bus.start = 1'b0; bus.img_width = '0; bus.img_height = '0;
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.win_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // 4x4 ramp, free flowing, start poked in the frame_done cycle
    fill_seq(16, 0);
    stream(4, 4, 1, 0, 100, 0, 1);
    compare_frame("f4x4", 4, 4);
    fw = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    lw = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    if (got_q.size() == 4) begin
      check_word("f4x4_first", got_q[0], pack9(fw));
      check_word("f4x4_last",  got_q[3], pack9(lw));
    end else begin
      check_int("f4x4_first_last_present", got_q.size(), 4);
    end
    @(negedge clk); #1;
    check_bit("start_at_frame_done_ignored", bus.busy, 1'b0);

    // Same frame with a 5-cycle downstream stall after the first window
    stream(4, 4, 1, 0, 100, 5, 0);
    compare_frame("f4x4_stall", 4, 4);

    // Geometry table: illegal starts set err, the final legal start clears it
    gv[0] = '{w: 2,    h: 3,    exp_err: 1'b1, exp_busy: 1'b0};
    gv[1] = '{w: 3,    h: 2,    exp_err: 1'b1, exp_busy: 1'b0};
    gv[2] = '{w: 641,  h: 8,    exp_err: 1'b1, exp_busy: 1'b0};
    gv[3] = '{w: 0,    h: 0,    exp_err: 1'b1, exp_busy: 1'b0};
    gv[4] = '{w: 3,    h: 3,    exp_err: 1'b0, exp_busy: 1'b1};
    fill_seq(9, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.img_width  = DIMW'(gv[i].w);
      bus.img_height = DIMW'(gv[i].h);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check_bit($sformatf("geom%0d_err", i),  bus.err,  gv[i].exp_err);
      check_bit($sformatf("geom%0d_busy", i), bus.busy, gv[i].exp_busy);
    end
    stream(3, 3, 0, 0, 100, 0, 0);
    compare_frame("f3x3", 3, 3);
    if (got_q.size() == 1) check_int("f3x3_centre", int'(got_q[0][DW*4 +: DW]), 4);

    // Random input gaps, then random gaps plus random backpressure
    fill_rand(40);
    stream(8, 5, 1, 30, 100, 0, 0);
    compare_frame("f8x5_gaps", 8, 5);
    fill_rand(40);
    stream(8, 5, 1, 40, 60, 0, 0);
    compare_frame("f8x5_bp", 8, 5);

    // Reset after 10 pixels of a 6x6 frame
    fill_seq(36, 50);
    @(negedge clk);
    bus.start = 1'b1; bus.img_width = DIMW'(6); bus.img_height = DIMW'(6);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      bus.pix_valid = 1'b1;
      bus.pix_in    = img[n];
      #1;
      if (bus.pix_ready) n++;
      @(negedge clk);
      cyc++;
    end
    check_int("midreset_pixels_sent", n, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bus.pix_valid = 1'b0;
    fill_seq(16, 200);
    stream(4, 4, 1, 0, 100, 0, 0);
    compare_frame("f4x4_after_reset", 4, 4);

    // Full-width frame exercises the wrap at MAX_WIDTH-1
    fill_rand(MAXW * 3);
    stream(MAXW, 3, 1, 0, 100, 0, 0);
    compare_frame("fmaxw", MAXW, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
